// File: rtl/four_bank_mem_resp.sv
// Banked main-memory responder: four word-interleaved banks with
// per-bank occupancy, same-cycle stall and a fixed two-cycle read latency.
module four_bank_mem_resp #(
    parameter int WORDS_LOG2  = 13,
    parameter int BANK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        wr,
    input  logic        rd,
    output logic [15:0] data_out,
    output logic        stall,
    output logic [3:0]  busy,
    output logic        err
);

    localparam int         DEPTH = 4 << WORDS_LOG2;
    localparam logic [2:0] LOAD  = 3'(BANK_CYCLES - 1);

    logic [15:0] r_mem [DEPTH];
    logic [2:0]  r_cnt [4];
    logic        r_s1_v;
    logic        r_s2_v;
    logic [15:0] r_s1_d;
    logic [15:0] r_s2_d;

    logic                  w_req;
    logic                  w_acc;
    logic [1:0]            w_bank;
    logic [WORDS_LOG2+1:0] w_idx;

    assign w_req  = rd | wr;
    assign w_bank = addr[2:1];
    // Bank selects the top of the flat index so each bank is a contiguous slice
    assign w_idx  = {w_bank, addr[WORDS_LOG2+2:3]};

    assign err   = (rd & wr) | (w_req & addr[0]);
    assign stall = w_req & ~err & busy[w_bank];
    assign w_acc = w_req & ~err & ~busy[w_bank];

    assign data_out = r_s2_v ? r_s2_d : 16'h0000;

    always_comb begin
        busy = '0;
        for (int b = 0; b < 4; b++) begin
            busy[b] = (r_cnt[b] != 3'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int b = 0; b < 4; b++) begin
                r_cnt[b] <= 3'd0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (w_acc && (w_bank == 2'(b))) begin
                    r_cnt[b] <= LOAD;
                end else if (r_cnt[b] != 3'd0) begin
                    r_cnt[b] <= r_cnt[b] - 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1_v <= 1'b0;
            r_s2_v <= 1'b0;
            r_s1_d <= 16'h0000;
            r_s2_d <= 16'h0000;
        end else begin
            r_s1_v <= w_acc & rd;
            r_s2_v <= r_s1_v;
            r_s2_d <= r_s1_d;
            if (w_acc && rd) begin
                r_s1_d <= r_mem[w_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 16'h0000;
            end
        end else if (w_acc && wr) begin
            r_mem[w_idx] <= data_in;
        end
    end

endmodule

// File: tb/tb_four_bank_mem_resp.sv
// Scoreboard bench for four_bank_mem_resp: stimulus queues expected read
// data with its arrival cycle; a negedge monitor pops and compares.
module tb_four_bank_mem_resp;

    logic        clk;
    logic        rst;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        wr;
    logic        rd;
    logic [15:0] data_out;
    logic        stall;
    logic [3:0]  busy;
    logic        err;

    typedef struct {
        int          cyc;
        logic [15:0] d;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   checks;
    int   errors;
    bit   en;

    four_bank_mem_resp #(
        .WORDS_LOG2 (13),
        .BANK_CYCLES(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .data_in (data_in),
        .wr      (wr),
        .rd      (rd),
        .data_out(data_out),
        .stall   (stall),
        .busy    (busy),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (en) begin
            if (q.size() > 0 && q[0].cyc == cyc) begin
                chk("rd_data", data_out, q[0].d);
                void'(q.pop_front());
            end else begin
                chk("idle_data", data_out, 16'h0000);
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic r, logic w, logic [15:0] a, logic [15:0] d);
        rd      = r;
        wr      = w;
        addr    = a;
        data_in = d;
    endtask

    task automatic expect_rd(logic [15:0] d);
        exp_t e;
        e.cyc = cyc + 2;
        e.d   = d;
        q.push_back(e);
    endtask

    task automatic idle(int n);
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        repeat (n) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        en     = 1'b0;
        rst    = 1'b0;
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        step();
        step();
        rst = 1'b1;
        #1;
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_stall", 16'(stall), 16'h0);
        chk("rst_err", 16'(err), 16'h0);
        chk("rst_dout", data_out, 16'h0);
        en = 1'b1;

        // read of untouched word after reset
        drive(1'b1, 1'b0, 16'h0040, 16'h0);
        #1;
        chk("rd0040_stall", 16'(stall), 16'h0);
        expect_rd(16'h0000);
        step();
        idle(4);

        // write then same-bank read: stalls until bank 2 frees
        drive(1'b0, 1'b1, 16'h1234, 16'hBEEF);
        #1;
        chk("wr1234_stall", 16'(stall), 16'h0);
        step();
        drive(1'b1, 1'b0, 16'h1234, 16'h0);
        #1;
        chk("raw_busy", 16'(busy), 16'h0004);
        for (int k = 1; k <= 3; k++) begin
            chk("raw_stall", 16'(stall), 16'h1);
            step();
            #1;
        end
        chk("raw_accept", 16'(stall), 16'h0);
        expect_rd(16'hBEEF);
        step();
        idle(5);

        // preload a line, one bank per cycle
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1, 16'h0100 + 16'(2 * k), 16'h1111 * 16'(k + 1));
            #1;
            chk("pre_stall", 16'(stall), 16'h0);
            step();
        end
        idle(5);

        // line streaming reads
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 16'h0100 + 16'(2 * k), 16'h0);
            #1;
            chk("line_stall", 16'(stall), 16'h0);
            if (k == 3) chk("line_busy_t3", 16'(busy), 16'h0007);
            expect_rd(16'h1111 * 16'(k + 1));
            step();
        end
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        #1;
        chk("line_busy_t4", 16'(busy), 16'h000E);
        idle(5);

        // same-bank burst on 0x0000
        drive(1'b0, 1'b1, 16'h0000, 16'hA5A5);
        step();
        idle(4);
        drive(1'b1, 1'b0, 16'h0000, 16'h0);
        for (int k = 0; k < 9; k++) begin
            #1;
            chk("burst_stall", 16'(stall), (k % 4 != 0) ? 16'h1 : 16'h0);
            if (k % 4 == 0) expect_rd(16'hA5A5);
            step();
        end
        idle(5);

        // illegal requests change nothing
        drive(1'b0, 1'b1, 16'h0010, 16'h5555);
        step();
        idle(4);
        drive(1'b1, 1'b1, 16'h0010, 16'hDEAD);
        #1;
        chk("rdwr_err", 16'(err), 16'h1);
        chk("rdwr_stall", 16'(stall), 16'h0);
        step();
        drive(1'b1, 1'b0, 16'h0001, 16'h0);
        #1;
        chk("odd_err", 16'(err), 16'h1);
        chk("odd_busy", 16'(busy), 16'h0);
        step();
        drive(1'b1, 1'b0, 16'h0010, 16'h0);
        #1;
        chk("rd0010_err", 16'(err), 16'h0);
        chk("rd0010_stall", 16'(stall), 16'h0);
        expect_rd(16'h5555);
        step();
        drive(1'b1, 1'b1, 16'h0010, 16'hDEAD);
        #1;
        chk("err_busybank", 16'(err), 16'h1);
        chk("err_nostall", 16'(stall), 16'h0);
        step();
        idle(5);

        // reset while a read is in flight
        drive(1'b0, 1'b1, 16'h0008, 16'h7777);
        step();
        idle(4);
        drive(1'b1, 1'b0, 16'h0008, 16'h0);
        step();
        rst = 1'b0;
        drive(1'b1, 1'b1, 16'h0008, 16'h0);
        drive(1'b0, 1'b1, 16'h0008, 16'h9999);
        step();
        rst = 1'b1;
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        #1;
        chk("midrst_busy", 16'(busy), 16'h0);
        step();
        drive(1'b1, 1'b0, 16'h0008, 16'h0);
        #1;
        chk("postrst_stall", 16'(stall), 16'h0);
        expect_rd(16'h0000);
        step();
        idle(5);

        chk("queue_drained", 16'(q.size()), 16'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
